// File: rtl/connect4_win_checker.sv
// Connect-4 result checker: snapshots both occupancy maps, then scans one anchor cell per cycle.
// Optional macro CONNECT4_EARLY_EXIT_EN ends the scan on the first winning anchor.
module connect4_win_checker #(
  parameter int unsigned COLS    = 7,
  parameter int unsigned ROWS    = 6,
  parameter int unsigned WIN_LEN = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [ROWS*COLS-1:0] red_player_i,
  input  logic [ROWS*COLS-1:0] yellow_player_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [1:0]           winner_o,
  output logic                 game_over_o,
  output logic [ROWS*COLS-1:0] win_mask_o
);

  localparam int unsigned Cells = ROWS * COLS;
  localparam int unsigned CellW = (Cells > 1) ? $clog2(Cells) : 1;
  localparam int unsigned RowW  = (ROWS > 1) ? $clog2(ROWS + 1) : 1;
  localparam int unsigned ColW  = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {StIdle, StCapture, StScan, StDone} state_e;

  state_e             state_q, state_d;
  logic [Cells-1:0]   red_q, red_d, yellow_q, yellow_d;
  logic [RowW-1:0]    row_q, row_d;
  logic [ColW-1:0]    col_q, col_d;
  logic               found_q, found_d;
  logic [1:0]         pend_win_q, pend_win_d;
  logic [Cells-1:0]   pend_mask_q, pend_mask_d;
  logic [1:0]         winner_q, winner_d;
  logic [Cells-1:0]   mask_q, mask_d;
  logic               game_over_q, game_over_d;

  logic [1:0]         hit_win;
  logic [Cells-1:0]   hit_mask, dmask;
  logic               last_anchor, scan_end;

  // Mask of the WIN_LEN cells from (r,c) along (dr,dc); zero when the run leaves the board.
  function automatic logic [Cells-1:0] dir_mask(input int r, input int c,
                                                input int dr, input int dc);
    logic [Cells-1:0] m;
    int last_r, last_c;
    m      = '0;
    last_r = r + (int'(WIN_LEN) - 1) * dr;
    last_c = c + (int'(WIN_LEN) - 1) * dc;
    if (last_r < int'(ROWS) && last_c >= 0 && last_c < int'(COLS)) begin
      for (int k = 0; k < int'(WIN_LEN); k++) begin
        m[CellW'((r + k * dr) * int'(COLS) + c + k * dc)] = 1'b1;
      end
    end
    return m;
  endfunction

  // Direction order H, V, D1, D2; red checked before yellow within each direction.
  always_comb begin
    hit_win  = 2'b00;
    hit_mask = '0;
    dmask    = '0;
    for (int d = 0; d < 4; d++) begin
      dmask = dir_mask(int'(row_q), int'(col_q), (d == 0) ? 0 : 1,
                       (d == 1) ? 0 : ((d == 3) ? -1 : 1));
      if (hit_win == 2'b00 && dmask != '0) begin
        if ((red_q & dmask) == dmask) begin
          hit_win  = 2'b01;
          hit_mask = dmask;
        end else if ((yellow_q & dmask) == dmask) begin
          hit_win  = 2'b10;
          hit_mask = dmask;
        end
      end
    end
  end

  assign last_anchor = (row_q == RowW'(ROWS - 1)) && (col_q == ColW'(COLS - 1));

  always_comb begin
    state_d     = state_q;
    red_d       = red_q;
    yellow_d    = yellow_q;
    row_d       = row_q;
    col_d       = col_q;
    found_d     = found_q;
    pend_win_d  = pend_win_q;
    pend_mask_d = pend_mask_q;
    winner_d    = winner_q;
    mask_d      = mask_q;
    game_over_d = game_over_q;
    scan_end    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i && !game_over_q) state_d = StCapture;
      end
      StCapture: begin
        red_d       = red_player_i;
        yellow_d    = yellow_player_i;
        row_d       = '0;
        col_d       = '0;
        found_d     = 1'b0;
        pend_win_d  = 2'b00;
        pend_mask_d = '0;
        state_d     = StScan;
      end
      StScan: begin
        if (!found_q && hit_win != 2'b00) begin
          found_d     = 1'b1;
          pend_win_d  = hit_win;
          pend_mask_d = hit_mask;
        end
        if (col_q == ColW'(COLS - 1)) begin
          col_d = '0;
          row_d = row_q + RowW'(1);
        end else begin
          col_d = col_q + ColW'(1);
        end
        scan_end = last_anchor;
`ifdef CONNECT4_EARLY_EXIT_EN
        if (!found_q && hit_win != 2'b00) scan_end = 1'b1;
`else
        scan_end = last_anchor;
`endif
        // Results are published on entry to StDone so they are visible while done is high.
        if (scan_end) begin
          state_d = StDone;
          if (found_d) begin
            winner_d = pend_win_d;
            mask_d   = pend_mask_d;
          end else if (&(red_q | yellow_q)) begin
            winner_d = 2'b11;
            mask_d   = '0;
          end else begin
            winner_d = 2'b00;
            mask_d   = '0;
          end
          game_over_d = (winner_d != 2'b00);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      red_q       <= '0;
      yellow_q    <= '0;
      row_q       <= '0;
      col_q       <= '0;
      found_q     <= 1'b0;
      pend_win_q  <= 2'b00;
      pend_mask_q <= '0;
      winner_q    <= 2'b00;
      mask_q      <= '0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      red_q       <= red_d;
      yellow_q    <= yellow_d;
      row_q       <= row_d;
      col_q       <= col_d;
      found_q     <= found_d;
      pend_win_q  <= pend_win_d;
      pend_mask_q <= pend_mask_d;
      winner_q    <= winner_d;
      mask_q      <= mask_d;
      game_over_q <= game_over_d;
    end
  end

  assign busy_o      = (state_q == StCapture) || (state_q == StScan);
  assign done_o      = (state_q == StDone);
  assign winner_o    = winner_q;
  assign game_over_o = game_over_q;
  assign win_mask_o  = mask_q;

endmodule

// File: tb/tb_connect4_win_checker.sv
// Table-driven bench for connect4_win_checker with a scoreboard of expected results.
module tb_connect4_win_checker;

  localparam int Cells = 42;
`ifdef CONNECT4_EARLY_EXIT_EN
  localparam bit Early = 1'b1;
`else
  localparam bit Early = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [Cells-1:0] red, yellow;
  logic             busy, done, game_over;
  logic [1:0]       winner;
  logic [Cells-1:0] win_mask;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string            name;
    logic [Cells-1:0] red;
    logic [Cells-1:0] yellow;
    logic [1:0]       win;
    logic [Cells-1:0] mask;
    int               anchor;
  } vec_t;

  typedef struct {
    string            name;
    logic [1:0]       win;
    logic [Cells-1:0] mask;
    int               lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[8];

  connect4_win_checker dut (
    .clk            (clk),
    .reset          (reset),
    .start_i        (start),
    .red_player_i   (red),
    .yellow_player_i(yellow),
    .busy_o         (busy),
    .done_o         (done),
    .winner_o       (winner),
    .game_over_o    (game_over),
    .win_mask_o     (win_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [Cells-1:0] bit1(input int a);
    logic [Cells-1:0] m;
    m    = '0;
    m[a] = 1'b1;
    return m;
  endfunction

  function automatic logic [Cells-1:0] run4(input int a, input int b, input int c, input int d);
    return bit1(a) | bit1(b) | bit1(c) | bit1(d);
  endfunction

  function automatic vec_t mk(input string n, input logic [Cells-1:0] r, input logic [Cells-1:0] y,
                              input logic [1:0] w, input logic [Cells-1:0] m, input int a);
    vec_t v;
    v.name = n; v.red = r; v.yellow = y; v.win = w; v.mask = m; v.anchor = a;
    return v;
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_done();
    exp_t e;
    bit   seen;
    int   n;
    seen = 1'b0;
    n    = 1;
    while (n <= 60 && !seen) begin
      if (done) seen = 1'b1;
      else begin
        @(posedge clk);
        #1 n++;
      end
    end
    e = sb.pop_front();
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s/timeout: got no done expected done at +%0d", e.name, e.lat);
    end else begin
      check({e.name, "/latency"}, 64'(n), 64'(e.lat));
      check({e.name, "/winner"}, 64'(winner), 64'(e.win));
      check({e.name, "/mask"}, 64'(win_mask), 64'(e.mask));
      check({e.name, "/game_over"}, 64'(game_over), 64'(e.win != 2'b00));
      @(posedge clk);
      #1 check({e.name, "/done_pulse"}, 64'(done), 64'(0));
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    do_reset();
    red    = v.red;
    yellow = v.yellow;
    e.name = v.name;
    e.win  = v.win;
    e.mask = v.mask;
    e.lat  = (Early && v.anchor >= 0) ? 3 + v.anchor : 44;
    sb.push_back(e);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check({v.name, "/busy"}, 64'(busy), 64'(1));
    wait_done();
  endtask

  initial begin
    logic [Cells-1:0] pat;
    bit               busy_seen, done_seen;
    pat = '0;
    // Paired-column checkerboard: runs never exceed two in any direction.
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 7; c++)
        if ((((c >> 1) + r) % 2) == 1) pat[r * 7 + c] = 1'b1;

    vecs[0] = mk("red_h0", run4(0, 1, 2, 3), '0, 2'b01, run4(0, 1, 2, 3), 0);
    vecs[1] = mk("yel_v20", 42'h7, run4(20, 27, 34, 41), 2'b10, run4(20, 27, 34, 41), 20);
    vecs[2] = mk("red_d2", run4(3, 9, 15, 21), bit1(10) | bit1(30) | bit1(40), 2'b01,
                 run4(3, 9, 15, 21), 3);
    vecs[3] = mk("wrap", run4(4, 5, 6, 7), '0, 2'b00, '0, -1);
    vecs[4] = mk("draw", pat, ~pat, 2'b11, '0, -1);
    vecs[5] = mk("dir_prio", run4(0, 7, 14, 21), run4(0, 1, 2, 3), 2'b10, run4(0, 1, 2, 3), 0);
    vecs[6] = mk("col_prio", run4(8, 9, 10, 11), run4(8, 9, 10, 11), 2'b01,
                 run4(8, 9, 10, 11), 8);
    vecs[7] = mk("low_anchor", run4(10, 11, 12, 13), run4(1, 8, 15, 22), 2'b10,
                 run4(1, 8, 15, 22), 1);

    red    = '0;
    yellow = '0;
    do_reset();
    check("rst/busy", 64'(busy), 64'(0));
    check("rst/done", 64'(done), 64'(0));
    check("rst/winner", 64'(winner), 64'(0));
    check("rst/game_over", 64'(game_over), 64'(0));
    check("rst/mask", 64'(win_mask), 64'(0));

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Restart mid-scan is ignored, then reset discards the scan.
    do_reset();
    red    = '0;
    yellow = run4(20, 27, 34, 41);
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    check("midrst/busy_t10", 64'(busy), 64'(1));
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    busy_seen = 1'b0;
    done_seen = 1'b0;
    repeat (50) begin
      if (busy) busy_seen = 1'b1;
      if (done) done_seen = 1'b1;
      @(posedge clk);
      #1;
    end
    check("midrst/busy", 64'(busy_seen), 64'(0));
    check("midrst/done", 64'(done_seen), 64'(0));
    check("midrst/winner", 64'(winner), 64'(0));
    check("midrst/game_over", 64'(game_over), 64'(0));
    check("midrst/mask", 64'(win_mask), 64'(0));

    // After a win, game_over blocks further scans.
    run_vec(vecs[0]);
    yellow = run4(20, 27, 34, 41);
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    busy_seen = 1'b0;
    done_seen = 1'b0;
    repeat (50) begin
      if (busy) busy_seen = 1'b1;
      if (done) done_seen = 1'b1;
      @(posedge clk);
      #1;
    end
    check("locked/busy", 64'(busy_seen), 64'(0));
    check("locked/done", 64'(done_seen), 64'(0));
    check("locked/winner", 64'(winner), 64'(1));
    check("locked/game_over", 64'(game_over), 64'(1));
    check("locked/mask", 64'(win_mask), 64'(42'hF));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
